// File: rtl/lcd_temp_buffer.sv
// Character buffer feeding the LCD sequencer: DS18B20 words become ASCII NOW/MIN/MAX lines
// in a 4x16 character map, read back through a one-cycle-latency request/address port.
module lcd_temp_buffer #(
  parameter logic [7:0] DEGREE_CHAR = 8'hDF
) (
  input  logic        LCD_BUF_CLK,
  input  logic        LCD_BUF_RESET,
  input  logic [15:0] TEMP_DATA,
  input  logic        TEMP_VALID,
  output logic        LCD_BUF_BUSY,
  output logic        LCD_BUF_DROPPED,
  input  logic        LCD_BUF_MEMORY_REQUEST,
  input  logic [8:0]  LCD_BUF_MEMORY_ADDRESS,
  output logic [7:0]  LCD_BUF_DATA_OUT,
  output logic        LCD_BUF_DATA_ENABLED
);

  localparam logic [127:0] LINE0     = "DS18B20 SENSOR  ";
  localparam logic [23:0]  LABEL_NOW = "NOW";
  localparam logic [23:0]  LABEL_MIN = "MIN";
  localparam logic [23:0]  LABEL_MAX = "MAX";
  localparam logic [7:0]   CH_DASH   = 8'h2D;
  localparam logic [7:0]   CH_PLUS   = 8'h2B;
  localparam logic [7:0]   CH_SPACE  = 8'h20;

  typedef enum logic [1:0] {IDLE, LATCH, CONV, WRITE} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  step_reg;
  logic [1:0]  line_reg;
  logic [15:0] cur_reg, min_reg, max_reg;
  logic        hist_valid_reg;
  logic [19:0] dd_reg;
  logic [7:0]  store_reg [0:14];
  logic        dropped_reg;
  logic [7:0]  data_out_reg;
  logic        enabled_reg;

  // FSM decoded controls
  logic busy, accept, conv_en, write_en, conv_last, write_last;

  // ---------------- state register ----------------
  always_ff @(posedge LCD_BUF_CLK or posedge LCD_BUF_RESET) begin
    if (LCD_BUF_RESET) state_reg <= IDLE;
    else               state_reg <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (TEMP_VALID) state_next = LATCH;
      LATCH:   state_next = CONV;
      CONV:    if (step_reg == 3'd7) state_next = WRITE;
      WRITE:   if (step_reg == 3'd4) state_next = (line_reg == 2'd3) ? IDLE : CONV;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    busy       = (state_reg != IDLE);
    accept     = (state_reg == IDLE) && TEMP_VALID;
    conv_en    = (state_reg == CONV);
    write_en   = (state_reg == WRITE);
    conv_last  = conv_en && (step_reg == 3'd7);
    write_last = write_en && (step_reg == 3'd4);
  end

  // ---------------- value selection and conversion ----------------
  logic [15:0] sel_value;
  logic [11:0] mag;
  logic [7:0]  int_part;
  logic [7:0]  frac_prod;
  logic [3:0]  frac_digit;

  always_comb begin
    case (line_reg)
      2'd2:    sel_value = min_reg;
      2'd3:    sel_value = max_reg;
      default: sel_value = cur_reg;
    endcase
  end

  // Only the low 12 bits of the magnitude reach the display (int = mag[11:4]).
  assign mag        = sel_value[15] ? (~sel_value[11:0] + 12'd1) : sel_value[11:0];
  assign int_part   = mag[11:4];
  assign frac_prod  = {4'd0, mag[3:0]} * 8'd10;
  assign frac_digit = frac_prod[7:4];

  // Double dabble: {hundreds, tens, units, binary}, one add-3/shift step per CONV cycle.
  logic [19:0] dd_src, dd_adj, dd_iter;
  assign dd_src = (step_reg == 3'd0) ? {12'd0, int_part} : dd_reg;
  assign dd_adj[7:0] = dd_src[7:0];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      logic [3:0] nib;
      assign nib = dd_src[8 + 4*gi +: 4];
      assign dd_adj[8 + 4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end
  endgenerate

  assign dd_iter = dd_adj << 1;

  // ---------------- write-side character ----------------
  logic [7:0] wr_char;
  logic [3:0] wr_base, wr_idx;

  always_comb begin
    case (step_reg)
      3'd0:    wr_char = sel_value[15] ? CH_DASH : CH_PLUS;
      3'd1:    wr_char = {4'h3, dd_reg[19:16]};
      3'd2:    wr_char = {4'h3, dd_reg[15:12]};
      3'd3:    wr_char = {4'h3, dd_reg[11:8]};
      default: wr_char = {4'h3, frac_digit};
    endcase
  end

  assign wr_base = (line_reg == 2'd1) ? 4'd0 : (line_reg == 2'd2) ? 4'd5 : 4'd10;
  assign wr_idx  = wr_base + {1'b0, step_reg};

  // ---------------- datapath registers ----------------
  always_ff @(posedge LCD_BUF_CLK or posedge LCD_BUF_RESET) begin
    if (LCD_BUF_RESET) begin
      step_reg       <= 3'd0;
      line_reg       <= 2'd1;
      cur_reg        <= 16'd0;
      min_reg        <= 16'd0;
      max_reg        <= 16'd0;
      hist_valid_reg <= 1'b0;
      dd_reg         <= 20'd0;
      dropped_reg    <= 1'b0;
    end else begin
      dropped_reg <= TEMP_VALID && busy;

      if (accept) cur_reg <= TEMP_DATA;

      if (state_reg == LATCH) begin
        // First sample after reset seeds both extremes.
        if (!hist_valid_reg || ($signed(cur_reg) < $signed(min_reg))) min_reg <= cur_reg;
        if (!hist_valid_reg || ($signed(cur_reg) > $signed(max_reg))) max_reg <= cur_reg;
        hist_valid_reg <= 1'b1;
        line_reg       <= 2'd1;
      end

      if (conv_en) dd_reg <= dd_iter;

      if (conv_last || write_last || !(conv_en || write_en)) step_reg <= 3'd0;
      else                                                   step_reg <= step_reg + 3'd1;

      if (write_last && line_reg != 2'd3) line_reg <= line_reg + 2'd1;
    end
  end

  always_ff @(posedge LCD_BUF_CLK or posedge LCD_BUF_RESET) begin
    if (LCD_BUF_RESET) begin
      for (int i = 0; i < 15; i++) store_reg[i] <= CH_DASH;
    end else if (write_en) begin
      store_reg[wr_idx] <= wr_char;
    end
  end

  // ---------------- read port ----------------
  logic [1:0]  rd_line;
  logic [3:0]  rd_col;
  logic [2:0]  rd_pos;
  logic [3:0]  rd_base, rd_idx;
  logic [23:0] rd_label;
  logic [7:0]  map_char;

  assign rd_line = LCD_BUF_MEMORY_ADDRESS[5:4];
  assign rd_col  = LCD_BUF_MEMORY_ADDRESS[3:0];
  assign rd_pos  = (rd_col == 4'd9) ? 3'd4 : {1'b0, rd_col[1:0]};
  assign rd_base = (rd_line == 2'd1) ? 4'd0 : (rd_line == 2'd2) ? 4'd5 : 4'd10;
  assign rd_idx  = rd_base + {1'b0, rd_pos};

  always_comb begin
    case (rd_line)
      2'd2:    rd_label = LABEL_MIN;
      2'd3:    rd_label = LABEL_MAX;
      default: rd_label = LABEL_NOW;
    endcase
  end

  always_comb begin
    map_char = CH_SPACE;
    if (LCD_BUF_MEMORY_ADDRESS[8:6] != 3'd0) begin
      map_char = CH_SPACE;
    end else if (rd_line == 2'd0) begin
      map_char = LINE0[{~rd_col, 3'b000} +: 8];
    end else begin
      case (rd_col)
        4'd0:                   map_char = rd_label[23:16];
        4'd1:                   map_char = rd_label[15:8];
        4'd2:                   map_char = rd_label[7:0];
        4'd3:                   map_char = "=";
        4'd4, 4'd5, 4'd6, 4'd7,
        4'd9:                   map_char = store_reg[rd_idx];
        4'd8:                   map_char = ".";
        4'd11:                  map_char = DEGREE_CHAR;
        4'd12:                  map_char = "C";
        default:                map_char = CH_SPACE;
      endcase
    end
  end

  always_ff @(posedge LCD_BUF_CLK or posedge LCD_BUF_RESET) begin
    if (LCD_BUF_RESET) begin
      data_out_reg <= 8'h00;
      enabled_reg  <= 1'b0;
    end else begin
      data_out_reg <= map_char;
      enabled_reg  <= LCD_BUF_MEMORY_REQUEST;
    end
  end

  assign LCD_BUF_BUSY         = busy;
  assign LCD_BUF_DROPPED      = dropped_reg;
  assign LCD_BUF_DATA_OUT     = data_out_reg;
  assign LCD_BUF_DATA_ENABLED = enabled_reg;

endmodule

// File: tb/tb_lcd_temp_buffer.sv
// Directed bench for lcd_temp_buffer: a display model queues expected characters for every
// read issued and compares them when the registered read data appears.
module tb_lcd_temp_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] temp_data = 16'd0;
  logic        temp_valid = 1'b0;
  logic        busy, dropped;
  logic        req = 1'b0;
  logic [8:0]  addr = 9'd0;
  logic [7:0]  data_out;
  logic        data_en;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_q [$];
  logic [7:0]  mstore [1:3][0:4];
  logic [15:0] m_cur, m_min, m_max;
  bit          m_valid;

  always #5 clk = ~clk;

  lcd_temp_buffer dut (
    .LCD_BUF_CLK            (clk),
    .LCD_BUF_RESET          (rst),
    .TEMP_DATA              (temp_data),
    .TEMP_VALID             (temp_valid),
    .LCD_BUF_BUSY           (busy),
    .LCD_BUF_DROPPED        (dropped),
    .LCD_BUF_MEMORY_REQUEST (req),
    .LCD_BUF_MEMORY_ADDRESS (addr),
    .LCD_BUF_DATA_OUT       (data_out),
    .LCD_BUF_DATA_ENABLED   (data_en)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    for (int l = 1; l <= 3; l++)
      for (int p = 0; p < 5; p++) mstore[l][p] = 8'h2D;
  endtask

  task automatic model_line(input int ln, input logic [15:0] t);
    int v, mag, ip, fr;
    v   = int'($signed(t));
    mag = (v < 0) ? -v : v;
    ip  = (mag / 16) % 256;
    fr  = ((mag % 16) * 10) / 16;
    mstore[ln][0] = (v < 0) ? "-" : "+";
    mstore[ln][1] = 8'(48 + ip / 100);
    mstore[ln][2] = 8'(48 + (ip / 10) % 10);
    mstore[ln][3] = 8'(48 + ip % 10);
    mstore[ln][4] = 8'(48 + fr);
  endtask

  task automatic model_sample(input logic [15:0] t);
    m_cur = t;
    if (!m_valid || $signed(t) < $signed(m_min)) m_min = t;
    if (!m_valid || $signed(t) > $signed(m_max)) m_max = t;
    m_valid = 1;
    model_line(1, m_cur);
    model_line(2, m_min);
    model_line(3, m_max);
  endtask

  function automatic logic [7:0] exp_char(input logic [8:0] a);
    string l0, lbl;
    int ln, col;
    l0  = "DS18B20 SENSOR  ";
    ln  = int'(a[5:4]);
    col = int'(a[3:0]);
    if (a[8:6] != 3'd0) return 8'h20;
    if (ln == 0) return l0[col];
    lbl = (ln == 1) ? "NOW" : (ln == 2) ? "MIN" : "MAX";
    if (col < 3) return lbl[col];
    if (col == 3) return "=";
    if (col >= 4 && col <= 7) return mstore[ln][col - 4];
    if (col == 8) return ".";
    if (col == 9) return mstore[ln][4];
    if (col == 11) return 8'hDF;
    if (col == 12) return "C";
    return 8'h20;
  endfunction

  // Drive one address with request held; the expected byte is queued now, checked next cycle.
  task automatic read_addr(input logic [8:0] a);
    logic [7:0] e;
    addr = a;
    req  = 1'b1;
    exp_q.push_back(exp_char(a));
    tick();
    e = exp_q.pop_front();
    chk($sformatf("en@%03h", a), data_en, 1'b1);
    chk($sformatf("data@%03h", a), data_out, e);
  endtask

  task automatic read_line(input int ln);
    for (int c = 0; c < 16; c++) read_addr(9'(ln * 16 + c));
  endtask

  // Feed one sample; optionally pulse a second TEMP_VALID drop_at cycles into the update.
  task automatic send(input logic [15:0] t, input int drop_at);
    int n, drops;
    temp_data  = t;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    n = 0;
    drops = 0;
    while (busy && n < 100) begin
      if (n == drop_at) begin
        temp_valid = 1'b1;
        temp_data  = 16'h1234;
      end
      tick();
      temp_valid = 1'b0;
      n++;
      if (dropped) drops++;
    end
    chk($sformatf("busy_len_%04h", t), n, 40);
    chk($sformatf("drops_%04h", t), drops, (drop_at >= 0) ? 1 : 0);
    model_sample(t);
    for (int l = 1; l <= 3; l++) read_line(l);
  endtask

  initial begin
    model_reset();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_dropped", dropped, 1'b0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_en", data_en, 1'b0);
    rst = 1'b0;
    tick();

    for (int l = 0; l < 4; l++) read_line(l);
    read_addr(9'h040);
    read_addr(9'h1C5);

    send(16'h0191, -1);
    send(16'hFF5E, -1);
    send(16'h07D0, -1);
    send(16'hFC90, -1);
    send(16'h000F, -1);
    send(16'hFFFF, -1);
    send(16'h0320, 10);

    // Enable drops one cycle after the request falls.
    req = 1'b0;
    tick();
    chk("en_fall", data_en, 1'b0);

    // Abort mid-CONV with an asynchronous reset; history and digits are cleared.
    req = 1'b1;
    temp_data  = 16'h0190;
    temp_valid = 1'b1;
    tick();
    temp_valid = 1'b0;
    tick(); tick(); tick(); tick();
    chk("pre_abort_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_en", data_en, 1'b0);
    tick();
    rst = 1'b0;
    model_reset();
    read_line(1);
    send(16'h0050, -1);

    req = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
